// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Shared types and parameter checks for the actuated
//               N-phase traffic-signal controller.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

  // Lamp-sequence states of the controller
  typedef enum logic [1:0] {
    LS_GREEN  = 2'd0,
    LS_YELLOW = 2'd1,
    LS_ALLRED = 2'd2,
    LS_FLASH  = 2'd3
  } light_state_t;

  // True when a set of timing parameters describes a buildable controller
  function automatic bit timing_ok(
    input int num_phases,
    input int min_green,
    input int max_green,
    input int yellow_time,
    input int allred_time,
    input int flash_half,
    input int tw
  );
    bit ok;
    ok = (num_phases >= 2) && (num_phases <= 8);
    ok = ok && (tw >= 1) && (tw <= 30);
    ok = ok && (min_green >= 1) && (max_green >= min_green);
    ok = ok && (yellow_time >= 1) && (allred_time >= 1) && (flash_half >= 1);
    if (ok) begin
      ok = (max_green < (1 << tw)) && (yellow_time < (1 << tw)) &&
           (allred_time < (1 << tw)) && (flash_half < (1 << tw));
    end
    return ok;
  endfunction

endpackage : traffic_pkg
`default_nettype wire

// File: rtl/tl_rr_select.sv
`default_nettype none
// ============================================================================
// Module      : tl_rr_select
// Description : Combinational round-robin picker. Scans cur+1, cur+2, ...
//               (mod NUM_PHASES, wrapping back to cur last) and returns the
//               first requesting index. next_idx is meaningful only when
//               any_req is high.
// Revision    : 1.0 - initial release
// ============================================================================
module tl_rr_select #(
  parameter int NUM_PHASES = 4
) (
  input  logic [NUM_PHASES-1:0]         req,
  input  logic [$clog2(NUM_PHASES)-1:0] cur,
  output logic [$clog2(NUM_PHASES)-1:0] next_idx,
  output logic                          any_req
);

  localparam int PW = $clog2(NUM_PHASES);

  logic [PW-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest requester wins
  always_comb begin
    any_req  = |req;
    next_idx = cur;
    idx      = cur;
    for (int k = NUM_PHASES; k >= 1; k--) begin
      idx = PW'((int'(cur) + k) % NUM_PHASES);
      if (req[idx]) begin
        next_idx = idx;
      end
    end
  end

endmodule : tl_rr_select
`default_nettype wire

// File: rtl/traffic_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : traffic_phase_ctrl
// Description : Actuated N-phase traffic-signal controller. Serves phases
//               round-robin with demand skipping, min/max green with
//               extension, yellow and all-red clearance, and red-flash mode.
//               All timing advances on the tick_en strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_PHASES  = 4,
  parameter int MIN_GREEN   = 5,
  parameter int MAX_GREEN   = 15,
  parameter int YELLOW_TIME = 2,
  parameter int ALLRED_TIME = 1,
  parameter int FLASH_HALF  = 4,
  parameter int TW          = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick_en,
  input  logic [NUM_PHASES-1:0]         demand,
  input  logic                          flash_req,
  output logic [NUM_PHASES-1:0]         green,
  output logic [NUM_PHASES-1:0]         yellow,
  output logic [NUM_PHASES-1:0]         red,
  output logic [$clog2(NUM_PHASES)-1:0] active_phase,
  output logic                          flashing
);

  localparam int PW = $clog2(NUM_PHASES);

  // Last timer value of each interval: a state of T ticks exits at T-1
  localparam logic [TW-1:0]         MIN_LAST   = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0]         MAX_LAST   = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0]         YEL_LAST   = TW'(YELLOW_TIME - 1);
  localparam logic [TW-1:0]         AR_LAST    = TW'(ALLRED_TIME - 1);
  localparam logic [TW-1:0]         FL_LAST    = TW'(FLASH_HALF - 1);
  localparam logic [PW-1:0]         LAST_PHASE = PW'(NUM_PHASES - 1);
  localparam logic [NUM_PHASES-1:0] PHASE_ONE  = NUM_PHASES'(1);

  if (!timing_ok(NUM_PHASES, MIN_GREEN, MAX_GREEN, YELLOW_TIME,
                 ALLRED_TIME, FLASH_HALF, TW)) begin : g_cfg_check
    $fatal(1, "traffic_phase_ctrl: illegal timing parameters");
  end

  light_state_t          state_q, state_d;
  logic [PW-1:0]         phase_q, phase_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [NUM_PHASES-1:0] dq_q, dq_d;
  logic                  toggle_q, toggle_d;

  logic [NUM_PHASES-1:0] phase_mask;
  logic                  others_req;
  logic [TW-1:0]         timer_inc;
  logic [PW-1:0]         phase_inc;
  logic [PW-1:0]         sel_idx;
  logic                  sel_any;

  assign phase_mask = PHASE_ONE << phase_q;
  assign others_req = |(dq_q & ~phase_mask);
  assign timer_inc  = timer_q + 1'b1;
  assign phase_inc  = (phase_q == LAST_PHASE) ? '0 : phase_q + 1'b1;

  tl_rr_select #(
    .NUM_PHASES (NUM_PHASES)
  ) u_rr_select (
    .req      (dq_q),
    .cur      (phase_q),
    .next_idx (sel_idx),
    .any_req  (sel_any)
  );

  // State, phase, timer, demand latch and flash toggle registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= LS_ALLRED;
      phase_q  <= LAST_PHASE;
      timer_q  <= '0;
      dq_q     <= '0;
      toggle_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      timer_q  <= timer_d;
      dq_q     <= dq_d;
      toggle_q <= toggle_d;
    end
  end

  // Next-state logic; demand latches every cycle, everything else only on ticks
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    timer_d  = timer_q;
    dq_d     = dq_q | demand;
    toggle_d = toggle_q;
    if (tick_en) begin
      case (state_q)
        LS_GREEN: begin
          // Live demand on the served phase extends green up to MAX_GREEN
          if (flash_req ||
              (others_req && (timer_q >= MIN_LAST) &&
               (!demand[phase_q] || (timer_q >= MAX_LAST)))) begin
            state_d = LS_YELLOW;
            timer_d = '0;
          end else if (timer_q != MAX_LAST) begin
            timer_d = timer_inc;
          end
        end
        LS_YELLOW: begin
          if (timer_q == YEL_LAST) begin
            state_d = LS_ALLRED;
            timer_d = '0;
          end else begin
            timer_d = timer_inc;
          end
        end
        LS_ALLRED: begin
          if (timer_q == AR_LAST) begin
            timer_d = '0;
            if (flash_req) begin
              state_d  = LS_FLASH;
              toggle_d = 1'b1;
            end else begin
              state_d = LS_GREEN;
              phase_d = sel_any ? sel_idx : phase_inc;
              dq_d    = dq_d & ~(PHASE_ONE << phase_d);
            end
          end else begin
            timer_d = timer_inc;
          end
        end
        LS_FLASH: begin
          // Leaving flash restarts service so phase 0 is next by default
          if (!flash_req) begin
            state_d = LS_ALLRED;
            phase_d = LAST_PHASE;
            timer_d = '0;
          end else if (timer_q == FL_LAST) begin
            toggle_d = ~toggle_q;
            timer_d  = '0;
          end else begin
            timer_d = timer_inc;
          end
        end
        default: begin
          state_d = LS_ALLRED;
          timer_d = '0;
        end
      endcase
    end
  end

  // Moore lamp decode from registered state only
  always_comb begin
    green    = '0;
    yellow   = '0;
    red      = '1;
    flashing = 1'b0;
    case (state_q)
      LS_GREEN: begin
        green = phase_mask;
        red   = ~phase_mask;
      end
      LS_YELLOW: begin
        yellow = phase_mask;
        red    = ~phase_mask;
      end
      LS_FLASH: begin
        flashing = 1'b1;
        red      = toggle_q ? '1 : '0;
      end
      default: begin
        red = '1;
      end
    endcase
  end

  assign active_phase = phase_q;

endmodule : traffic_phase_ctrl
`default_nettype wire

// File: tb/tb_traffic_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_phase_ctrl
// Description : Self-checking bench for traffic_phase_ctrl: directed
//               scenarios plus randomized traffic against a behavioural
//               model that tracks elapsed ticks per interval.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_ctrl;

  localparam int NP    = 4;
  localparam int MIN_G = 5;
  localparam int MAX_G = 15;
  localparam int YEL   = 2;
  localparam int AR    = 1;
  localparam int FH    = 4;
  localparam int TW    = 8;

  logic          clk       = 1'b0;
  logic          rst       = 1'b0;
  logic          tick_en   = 1'b0;
  logic          flash_req = 1'b0;
  logic [NP-1:0] demand    = '0;
  logic [NP-1:0] green, yellow, red;
  logic [1:0]    active_phase;
  logic          flashing;

  int n_checks = 0;
  int n_pass   = 0;

  traffic_phase_ctrl #(
    .NUM_PHASES (NP), .MIN_GREEN (MIN_G), .MAX_GREEN (MAX_G),
    .YELLOW_TIME(YEL), .ALLRED_TIME(AR), .FLASH_HALF(FH), .TW(TW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick_en      (tick_en),
    .demand       (demand),
    .flash_req    (flash_req),
    .green        (green),
    .yellow       (yellow),
    .red          (red),
    .active_phase (active_phase),
    .flashing     (flashing)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef enum {M_GO, M_AMBER, M_CLEAR, M_FLASH} mkind_t;
  mkind_t        m_kind;
  int            m_phase;
  int            m_ticks;        // ticks completed in current interval
  int            m_flash_ticks;  // ticks spent in flash so far
  bit [NP-1:0]   m_calls;

  logic [NP-1:0] prev_green;
  int            q_served[$];

  function automatic void model_reset();
    m_kind        = M_CLEAR;
    m_phase       = NP - 1;
    m_ticks       = 0;
    m_flash_ticks = 0;
    m_calls       = '0;
  endfunction

  function automatic void model_step();
    bit          others;
    int          nxt;
    bit [NP-1:0] prev;
    prev   = m_calls;
    others = 1'b0;
    for (int q = 0; q < NP; q++) if (q != m_phase && prev[q]) others = 1'b1;
    nxt = (m_phase + 1) % NP;
    for (int k = NP; k >= 1; k--) if (prev[(m_phase + k) % NP]) nxt = (m_phase + k) % NP;
    m_calls = m_calls | demand;
    if (tick_en) begin
      case (m_kind)
        M_GO: begin
          m_ticks++;
          if (flash_req || (others && m_ticks >= MIN_G &&
                            (!demand[m_phase] || m_ticks >= MAX_G))) begin
            m_kind  = M_AMBER;
            m_ticks = 0;
          end
        end
        M_AMBER: begin
          m_ticks++;
          if (m_ticks >= YEL) begin
            m_kind  = M_CLEAR;
            m_ticks = 0;
          end
        end
        M_CLEAR: begin
          m_ticks++;
          if (m_ticks >= AR) begin
            m_ticks = 0;
            if (flash_req) begin
              m_kind        = M_FLASH;
              m_flash_ticks = 0;
            end else begin
              m_kind       = M_GO;
              m_phase      = nxt;
              m_calls[nxt] = 1'b0;
            end
          end
        end
        M_FLASH: begin
          if (!flash_req) begin
            m_kind  = M_CLEAR;
            m_phase = NP - 1;
            m_ticks = 0;
          end else begin
            m_flash_ticks++;
          end
        end
        default: ;
      endcase
    end
  endfunction

  function automatic logic [31:0] exp_green();
    return (m_kind == M_GO) ? (32'd1 << m_phase) : 32'd0;
  endfunction

  function automatic logic [31:0] exp_yellow();
    return (m_kind == M_AMBER) ? (32'd1 << m_phase) : 32'd0;
  endfunction

  function automatic logic [31:0] exp_red();
    if (m_kind == M_GO || m_kind == M_AMBER) return ~(32'd1 << m_phase) & 32'hF;
    if (m_kind == M_FLASH) return (((m_flash_ticks / FH) % 2) == 0) ? 32'hF : 32'h0;
    return 32'hF;
  endfunction

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic compare_all();
    check_val("green",    32'(green),        exp_green());
    check_val("yellow",   32'(yellow),       exp_yellow());
    check_val("red",      32'(red),          exp_red());
    check_val("phase",    32'(active_phase), 32'(m_phase));
    check_val("flashing", 32'(flashing),     32'(m_kind == M_FLASH));
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later
  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    #1;
    compare_all();
    if (green != prev_green && green != '0) begin
      for (int q = 0; q < NP; q++) if (green[q]) q_served.push_back(q);
    end
    prev_green = green;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    step();
    step();
    rst = 1'b0;
  endtask

  int          cnt;
  logic [NP-1:0] prev_red;
  logic [NP-1:0] hold;

  initial begin
    prev_green = '0;
    hold       = '0;
    #2;

    // 1: reset state, first green on phase 0, resting with no demand
    tick_en = 1'b1;
    do_reset();
    check_val("rst_red",   32'(red),          32'hF);
    check_val("rst_phase", 32'(active_phase), 32'd3);
    step();
    check_val("first_green", 32'(green), 32'h1);
    repeat (30) step();
    check_val("rest_green", 32'(green), 32'h1);

    // 2: single call on phase 2 skips phase 1
    q_served.delete();
    demand = 4'b0100;
    step();
    demand = '0;
    repeat (20) step();
    check_val("skip_count", 32'(q_served.size()), 32'd1);
    check_val("skip_phase", (q_served.size() > 0) ? 32'(q_served[0]) : 32'hFFFF, 32'd2);

    // 3: calls on 1 and 3 served in round-robin order
    do_reset();
    step();
    q_served.delete();
    demand = 4'b1010;
    step();
    demand = '0;
    repeat (40) step();
    check_val("rr_count", 32'(q_served.size()), 32'd2);
    check_val("rr_first", (q_served.size() > 0) ? 32'(q_served[0]) : 32'hFFFF, 32'd1);
    check_val("rr_second", (q_served.size() > 1) ? 32'(q_served[1]) : 32'hFFFF, 32'd3);

    // 4: held demand on phase 0 extends green to the maximum
    do_reset();
    demand = 4'b0001;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 2) demand = 4'b0011;
      if (c == 3) demand = 4'b0001;
      step();
      if (green == 4'b0001) cnt++;
    end
    demand = '0;
    check_val("max_green_len", 32'(cnt), 32'd15);

    // 5: flash request mid-green, red flashes, then service restarts at 0
    do_reset();
    step();
    step();
    flash_req = 1'b1;
    repeat (10) step();
    check_val("flash_on", 32'(flashing), 32'd1);
    cnt = 0;
    prev_red = red;
    for (int c = 0; c < 16; c++) begin
      step();
      if (red != prev_red) cnt++;
      prev_red = red;
    end
    check_val("flash_toggles", 32'(cnt), 32'd4);
    flash_req = 1'b0;
    step();
    check_val("flash_exit_red", 32'(red), 32'hF);
    check_val("flash_exit_flag", 32'(flashing), 32'd0);
    step();
    check_val("flash_exit_green", 32'(green), 32'h1);

    // 6: slow timebase and an asynchronous reset during yellow
    do_reset();
    cnt = 0;
    for (int c = 0; c < 300 && yellow == '0; c++) begin
      tick_en = (c % 3 == 0);
      demand  = (c == 10) ? 4'b0010 : 4'b0000;
      step();
    end
    demand = '0;
    check_val("reach_yellow", 32'(|yellow), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_val("async_red",    32'(red),          32'hF);
    check_val("async_green",  32'(green),        32'h0);
    check_val("async_yellow", 32'(yellow),       32'h0);
    check_val("async_phase",  32'(active_phase), 32'd3);
    model_reset();
    step();
    rst = 1'b0;
    tick_en = 1'b1;

    // Randomized traffic with occasional held calls and flash requests
    for (int c = 0; c < 4000; c++) begin
      tick_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) hold = NP'($urandom_range(0, 15)) & NP'($urandom_range(0, 15));
      for (int q = 0; q < NP; q++) demand[q] = hold[q] | ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 299) == 0) flash_req = ~flash_req;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_traffic_phase_ctrl
`default_nettype wire
